// File: rtl/bcd_xs3_seq_ctrl_if.sv
// Operand/result bundle for the sequential binary -> BCD -> excess-3 converter.
`timescale 1ns/1ps
interface bcd_xs3_seq_ctrl_if #(
  parameter int N = 2,
  parameter int W = 8
);
  // Both channels use valid/ready. A transfer happens on a rising edge where valid
  // and ready are both high. Once valid is raised, it and its payload stay stable
  // until that edge. Ready may depend on state, but never on valid.
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   bin_in;
  logic           out_valid;
  logic           out_ready;
  logic [4*N-1:0] bcd_out;
  logic [4*N-1:0] xs3_out;
  logic           ovf;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, xs3_out, ovf
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, xs3_out, ovf
  );
endinterface

// File: rtl/bcd_xs3_seq_ctrl.sv
// Sequential double-dabble binary-to-BCD converter. A single shared add-3 unit then
// produces the excess-3 code one digit per cycle.
`timescale 1ns/1ps
module bcd_xs3_seq_ctrl #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_xs3_seq_ctrl_if.slave     bus,
  output logic [1:0]            dbg_state_o
);

  localparam int BW = 4 * N;
  localparam int CW = $clog2(W + 1);
  localparam int DW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    XS3  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    sr_q, sr_d;
  logic [BW-1:0]   acc_q, acc_d;
  logic            ovf_q, ovf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dig_q, dig_d;
  logic [BW-1:0]   xs3_acc_q, xs3_acc_d;
  logic [BW-1:0]   bcd_out_q, bcd_out_d;
  logic [BW-1:0]   xs3_out_q, xs3_out_d;
  logic            ovf_out_q, ovf_out_d;
  logic            rst_ok_q;

  logic [BW-1:0]   adj;
  logic [BW+W:0]   sh;
  logic [3:0]      cur_dig;
  logic [BW-1:0]   xs3_next;
  logic            accept;

  // Release is taken one edge after rst_n rises, so the first accept is on the second edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_ok_q <= 1'b0;
    else        rst_ok_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      dig_q     <= '0;
      xs3_acc_q <= '0;
      bcd_out_q <= '0;
      xs3_out_q <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      xs3_acc_q <= xs3_acc_d;
      bcd_out_q <= bcd_out_d;
      xs3_out_q <= xs3_out_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  // Double-dabble correction: any digit >= 5 gets +3 before the shift.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < N; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    sh = {1'b0, adj, sr_q} << 1;
  end

  // Shared add-3 unit. An overflowed result is saturated to all nines here.
  always_comb begin
    cur_dig  = ovf_q ? 4'h9 : acc_q[{dig_q, 2'b00} +: 4];
    xs3_next = xs3_acc_q;
    xs3_next[{dig_q, 2'b00} +: 4] = cur_dig + 4'd3;
  end

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    dig_d     = dig_q;
    xs3_acc_d = xs3_acc_q;
    bcd_out_d = bcd_out_q;
    xs3_out_d = xs3_out_q;
    ovf_out_d = ovf_out_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sr_d      = bus.bin_in;
          acc_d     = '0;
          ovf_d     = 1'b0;
          cnt_d     = CW'(W);
          dig_d     = '0;
          xs3_acc_d = '0;
          state_d   = CONV;
        end
      end
      CONV: begin
        acc_d = sh[BW+W-1:W];
        sr_d  = sh[W-1:0];
        ovf_d = ovf_q | sh[BW+W];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          dig_d   = '0;
          state_d = XS3;
        end
      end
      XS3: begin
        xs3_acc_d = xs3_next;
        if (dig_q == DW'(N - 1)) begin
          bcd_out_d = ovf_q ? {N{4'h9}} : acc_q;
          xs3_out_d = xs3_next;
          ovf_out_d = ovf_q;
          state_d   = DONE;
        end else begin
          dig_d = dig_q + DW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready stays high throughout reset. After release it drops until the synchroniser settles.
  assign bus.in_ready  = (state_q == IDLE) && (rst_ok_q || !rst_n);
  assign bus.out_valid = (state_q == DONE);
  assign bus.bcd_out   = bcd_out_q;
  assign bus.xs3_out   = xs3_out_q;
  assign bus.ovf       = ovf_out_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// Self-checking bench for bcd_xs3_seq_ctrl (N=2, W=8) built around a result scoreboard.
`timescale 1ns/1ps
module tb_bcd_xs3_seq_ctrl;
  localparam int N = 2;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  dbg_state;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [16:0] exp_q[$];

  bcd_xs3_seq_ctrl_if #(.N(N), .W(W)) bus();

  bcd_xs3_seq_ctrl #(.N(N), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: {ovf, xs3[7:0], bcd[7:0]}
  function automatic logic [16:0] ref_model(input logic [7:0] v);
    logic [7:0] t8, o8;
    logic [3:0] t, o;
    if (v > 8'd99) return {1'b1, 8'hCC, 8'h99};
    t8 = v / 8'd10;
    o8 = v % 8'd10;
    t  = t8[3:0];
    o  = o8[3:0];
    return {1'b0, t + 4'd3, o + 4'd3, t, o};
  endfunction

  // scoreboard: pop and compare at every output handshake
  always begin
    logic [16:0] e;
    @(negedge clk);
    #2;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: got ovf=%b xs3=%h bcd=%h with empty queue",
                 bus.ovf, bus.xs3_out, bus.bcd_out);
      end else begin
        e = exp_q.pop_front();
        if ({bus.ovf, bus.xs3_out, bus.bcd_out} !== e)
          begin
            failures++;
            $display("FAIL result: got ovf=%b xs3=%h bcd=%h expected ovf=%b xs3=%h bcd=%h",
                     bus.ovf, bus.xs3_out, bus.bcd_out, e[16], e[15:8], e[7:0]);
          end
      end
    end
  end

  // driver: wait for in_ready, present v, push expected on accepting edge
  task automatic send(input logic [7:0] v);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready never rose for operand %0d", v);
    end else begin
      bus.in_valid = 1'b1;
      bus.bin_in   = v;
      @(posedge clk);
      exp_q.push_back(ref_model(v));
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #4;
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_drain: %0d results outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++;
    if ({bus.ovf, bus.xs3_out, bus.bcd_out} !== 17'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", {bus.ovf, bus.xs3_out, bus.bcd_out});
    end
    checks++;
    if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] vals [6];
    int k;
    vals = '{8'd0, 8'd99, 8'd100, 8'd255, 8'd7, 8'd60};
    bus.out_ready = 1'b1;
    foreach (vals[j]) begin
      send(vals[j]);
      // send returns at the negedge after the accepting edge; k counts later edges
      k = 0;
      for (int i = 1; i <= 40; i++) begin
        @(posedge clk);
        #1;
        if (bus.out_valid === 1'b1) begin
          k = i;
          break;
        end
      end
      checks++;
      if (k + 1 != W + N + 1) begin
        failures++;
        $display("FAIL latency_%0d: got %0d edges expected %0d", vals[j], k + 1, W + N + 1);
      end
      @(negedge clk);
    end
    wait_drain("basic");
  endtask

  task automatic test_backpressure();
    bit seen;
    bus.out_ready = 1'b0;
    send(8'd57);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL bp_out_valid_timeout: out_valid never rose"); end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.bcd_out !== 8'h57 || bus.xs3_out !== 8'h8A ||
          bus.ovf !== 1'b0 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: got valid=%b bcd=%h xs3=%h ovf=%b in_ready=%b expected 1 57 8a 0 0",
                 c, bus.out_valid, bus.bcd_out, bus.xs3_out, bus.ovf, bus.in_ready);
      end
      bus.in_valid = c[0];
      bus.bin_in   = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain("bp");
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL bp_ignored_input: got out_valid=1 after hold expected 0"); end
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b1;
    send(8'd200);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL midrst_ctrl: got valid=%b in_ready=%b state=%0d expected 0 1 0",
               bus.out_valid, bus.in_ready, dbg_state);
    end
    checks++;
    if ({bus.ovf, bus.xs3_out, bus.bcd_out} !== 17'h0) begin
      failures++;
      $display("FAIL midrst_outputs: got %h expected 0", {bus.ovf, bus.xs3_out, bus.bcd_out});
    end
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b1;
    bus.bin_in   = 8'd42;
    @(posedge clk);
    #1;
    checks++;
    if (dbg_state !== 2'd0) begin failures++; $display("FAIL rst_sync_edge1: got state %0d expected 0", dbg_state); end
    @(posedge clk);
    exp_q.push_back(ref_model(8'd42));
    #1;
    checks++;
    if (dbg_state !== 2'd1) begin failures++; $display("FAIL rst_sync_edge2: got state %0d expected 1", dbg_state); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_drain("midrst");
  endtask

  task automatic test_back_to_back();
    int  prev_cyc;
    bit  found;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    prev_cyc = 0;
    for (int v = 0; v < 256; v++) begin
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.in_ready === 1'b1) begin
          found = 1'b1;
          break;
        end
      end
      if (!found) begin
        checks++;
        failures++;
        $display("FAIL sweep_timeout: in_ready never rose for operand %0d", v);
        break;
      end
      bus.bin_in = 8'(v);
      if (v > 0) begin
        checks++;
        if (cyc - prev_cyc != W + N + 2) begin
          failures++;
          $display("FAIL sweep_interval_%0d: got %0d cycles expected %0d", v, cyc - prev_cyc, W + N + 2);
        end
      end
      prev_cyc = cyc;
      @(posedge clk);
      exp_q.push_back(ref_model(8'(v)));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_drain("sweep");
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.bin_in    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_xs3_seq_ctrl.md
BCD_XS3_SEQ_CTRL -- requirements
Module: bcd_xs3_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 2: number of BCD/XS3 output digits.
REQ-002 SHALL have parameter W, default 8: binary input width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: bin_in is valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts a new operand.
REQ-007 SHALL have port bin_in, input, W: unsigned binary operand.
REQ-008 SHALL have port out_valid, output, 1: result is valid.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-010 SHALL have port bcd_out, output, 4N: packed BCD result, digit 0 in [3:0].
REQ-011 SHALL have port xs3_out, output, 4N: excess-3 code of bcd_out, per digit.
REQ-012 SHALL have port ovf, output, 1: operand exceeds 10^N-1.

Function
REQ-013 SHALL implement FSM states IDLE, CONV, XS3, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; an operand is accepted on an edge with in_valid&&in_ready.
REQ-015 On accept, SHALL:
  - latch bin_in into a W-bit shift register;
  - clear the 4N-bit BCD accumulator and the overflow flag;
  - load a bit counter with W;
  - enter CONV.
REQ-016 In CONV, each cycle SHALL do one double-dabble step:
  - every accumulator digit >=5 gets +3 (mod 16);
  - then {carry, accumulator, shift register} shifts left by 1;
  - the counter decrements.
REQ-017 A 1 shifted out of the accumulator MSB in any CONV cycle SHALL set the sticky overflow flag.
REQ-018 SHALL leave CONV for XS3 after exactly W CONV cycles, i.e. when the counter reaches 0.
REQ-019 XS3 SHALL time-share one 4-bit add-3 unit across the digits:
  - one digit per cycle, digit 0 first;
  - N cycles total;
  - a digit index counter selects the digit.
REQ-020 Digit index SHALL wrap from N-1 to DONE; no digit is processed twice.
REQ-021 If the overflow flag is set at XS3 entry, SHALL still run all N XS3 cycles, but:
  - every BCD digit is saturated to 4'h9 before processing;
  - every XS3 digit therefore becomes 4'hC.
REQ-022 In DONE, SHALL hold out_valid=1 with bcd_out, xs3_out and ovf stable until out_ready=1.
REQ-023 SHALL return to IDLE on the edge with out_valid&&out_ready; out_valid falls on that edge.
REQ-024 Latency SHALL be: out_valid rises exactly W+N+1 edges after the accepting edge (1 load, W CONV, N XS3).
REQ-025 in_valid and bin_in changes outside IDLE SHALL be ignored; there is no queuing.
REQ-026 Back-to-back operation: in_ready rises in the cycle after the output handshake; minimum issue interval is W+N+2 cycles.
REQ-027 bcd_out, xs3_out and ovf SHALL be registered and SHALL change only on entry to DONE or on reset.
REQ-028 All arithmetic SHALL be unsigned; digit adds are 4-bit and discard the carry.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, force:
  - state=IDLE;
  - in_ready=1, out_valid=0;
  - bcd_out=0, xs3_out=0, ovf=0;
  - all counters and shift registers to 0.
REQ-030 Reset mid-CONV or mid-XS3 SHALL abort the operation with no output; the first post-reset accept starts a fresh conversion.
REQ-031 Deassertion SHALL be synchronised to clk; the first accept is possible on the second edge after rst_n rises.

Verification (N=2, W=8)
REQ-032 Scenario: accept bin_in=0 -> out_valid after 11 edges, bcd_out=8'h00, xs3_out=8'h33, ovf=0.
REQ-033 Scenario: bin_in=99 -> bcd_out=8'h99, xs3_out=8'hCC, ovf=0.
REQ-034 Scenario: bin_in=100 and bin_in=255 -> ovf=1, bcd_out=8'h99, xs3_out=8'hCC.
REQ-035 Scenario: bin_in=57 with out_ready=0 for 5 cycles ->
  - bcd_out=8'h57 and xs3_out=8'h8A held stable with out_valid=1 throughout;
  - in_ready=0 throughout, and in_valid pulses are ignored.
REQ-036 Scenario: rst_n pulsed low in CONV cycle 4 -> outputs zero immediately; next operand 42 yields bcd_out=8'h42, xs3_out=8'h75.
REQ-037 Scenario: exhaustive sweep 0..255 back-to-back with out_ready=1 ->
  - each result matches the reference model;
  - the interval between accepts is exactly 12 cycles.
